// File: rtl/g_lextend.sv
// g_lextend: sequential sign/zero extender.
// Keeps the low w = op[4:0] bits of in1 and fills bits w..31 with the sign bit
// in1[w-1] or with zero. The fill is written LANE bits per cycle, and the
// block uses valid/ready handshakes on its input and output.
// LANE must be 1, 2, 4, 8 or 16.
module g_lextend #(
   parameter int unsigned LANE = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] op,
   input  logic        sext,
   input  logic [31:0] in1,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out,
   output logic        busy
);

   typedef enum logic [1:0] {StIdle, StFill, StDone} state_e;

   state_e      state_q;
   logic [31:0] res_q;
   logic [5:0]  idx_q;
   logic        fill_q;

   logic [4:0]  w;
   logic [4:0]  w_m1;
   logic [31:0] keep_mask;
   logic        sign_bit;
   logic [6:0]  idx_end;
   logic        fill_last;
   logic [31:0] fill_mask;
   logic [31:0] res_fill;
   logic        unused_op;

   assign w         = op[4:0];
   assign unused_op = ^op[31:5];
   assign w_m1      = w - 5'd1;
   // Bits below w survive the accept; w=0 keeps nothing.
   assign keep_mask = (32'd1 << w) - 32'd1;
   // The subtraction wraps for w=0, but that case is masked out here.
   assign sign_bit  = sext & (w != 5'd0) & in1[w_m1];
   // 7-bit sum so idx+LANE never wraps before the comparison.
   assign idx_end   = {1'b0, idx_q} + 7'(LANE);
   assign fill_last = (idx_end >= 7'd32);

   // Select the lane of bits idx..idx+LANE-1 written this FILL cycle.
   always_comb begin
      fill_mask = '0;
      for (int i = 0; i < 32; i++) begin
         fill_mask[i] = (7'(i) >= {1'b0, idx_q}) && (7'(i) < idx_end);
      end
   end

   // Next res value for one FILL cycle.
   always_comb begin
      res_fill = fill_q ? (res_q | fill_mask) : (res_q & ~fill_mask);
   end

   // Control FSM together with the result, index and fill-bit registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         res_q   <= '0;
         idx_q   <= '0;
         fill_q  <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (in_valid) begin
                  res_q   <= in1 & keep_mask;
                  idx_q   <= {1'b0, w};
                  fill_q  <= sign_bit;
                  state_q <= StFill;
               end
            end
            StFill: begin
               res_q <= res_fill;
               idx_q <= idx_end[5:0];
               if (fill_last) begin
                  state_q <= StDone;
               end
            end
            StDone: begin
               if (out_ready) begin
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign busy      = (state_q != StIdle);
   assign out_valid = (state_q == StDone);
   assign in_ready  = !busy && rst_n;
   assign out       = res_q;

endmodule

// File: tb/tb_g_lextend.sv
// Bench for g_lextend: three instances (LANE = 4, 1, 16), each shadowed by a
// cycle-level reference model, plus directed transactions with literal results.
module tb_g_lextend;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   logic        iv[3];
   logic        ordy[3];
   logic        sx[3];
   logic        ir[3];
   logic        ov[3];
   logic        bz[3];
   logic [31:0] op_s[3];
   logic [31:0] in1_s[3];
   logic [31:0] out_s[3];

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Expected result: low w bits of in1, rest filled with in1[w-1] or 0.
   function automatic logic [31:0] ext(input logic [31:0] op, input logic s,
                                       input logic [31:0] d);
      int w;
      logic [31:0] r;
      w = int'(op[4:0]);
      r = '0;
      for (int i = 0; i < 32; i++) begin
         if (i < w) r[i] = d[i];
         else if (w > 0 && s) r[i] = d[w-1];
      end
      return r;
   endfunction

   function automatic int fill_cycles(input int w, input int l);
      return (32 - w + l - 1) / l;
   endfunction

   for (genvar g = 0; g < 3; g++) begin : g_lane
      localparam int unsigned L = (g == 0) ? 4 : (g == 1) ? 1 : 16;

      g_lextend #(.LANE(L)) dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .in_valid  (iv[g]),
         .in_ready  (ir[g]),
         .op        (op_s[g]),
         .sext      (sx[g]),
         .in1       (in1_s[g]),
         .out_valid (ov[g]),
         .out_ready (ordy[g]),
         .out       (out_s[g]),
         .busy      (bz[g])
      );

      logic        m_busy = 1'b0;
      logic        m_valid = 1'b0;
      int          m_cnt = 0;
      logic [31:0] m_res = '0;

      // Reference: a request waits fill_cycles() cycles, then holds until taken.
      always @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            m_busy  <= 1'b0;
            m_valid <= 1'b0;
            m_cnt   <= 0;
            m_res   <= '0;
         end else if (!m_busy) begin
            if (iv[g]) begin
               m_busy <= 1'b1;
               m_cnt  <= fill_cycles(int'(op_s[g][4:0]), int'(L));
               m_res  <= ext(op_s[g], sx[g], in1_s[g]);
            end
         end else if (!m_valid) begin
            if (m_cnt == 1) m_valid <= 1'b1;
            m_cnt <= m_cnt - 1;
         end else if (ordy[g]) begin
            m_busy  <= 1'b0;
            m_valid <= 1'b0;
         end
      end

      // Compare every cycle, away from the active edge.
      always @(negedge clk) begin
         check($sformatf("lane%0d in_ready", L), ir[g], !m_busy && rst_n);
         check($sformatf("lane%0d busy", L), bz[g], m_busy);
         check($sformatf("lane%0d out_valid", L), ov[g], m_valid);
         if (m_valid) check($sformatf("lane%0d out", L), out_s[g], m_res);
         if (!rst_n) check($sformatf("lane%0d out in reset", L), out_s[g], 32'h0);
      end
   end

   // Drive one request on instance k and check its result and latency.
   task automatic run_dir(input int k, input logic [31:0] op, input logic s,
                          input logic [31:0] d, input logic [31:0] exp, input int lat,
                          input bit hold);
      int n;
      n = 0;
      while (!ir[k] && n < 200) begin
         @(posedge clk); #2;
         n++;
      end
      if (!ir[k]) check("in_ready wait timeout", ir[k], 1'b1);
      op_s[k]  = op;
      sx[k]    = s;
      in1_s[k] = d;
      iv[k]    = 1'b1;
      ordy[k]  = !hold;
      @(posedge clk); #2;
      // Scramble inputs after accept; the result must come from registered state.
      iv[k]    = 1'b0;
      op_s[k]  = $urandom;
      in1_s[k] = $urandom;
      sx[k]    = ~s;
      n = 1;
      while (!ov[k] && n < 100) begin
         @(posedge clk); #2;
         n++;
      end
      check($sformatf("latency op=%h", op), n, lat);
      check($sformatf("result op=%h", op), out_s[k], exp);
   endtask

   initial begin
      int seen;
      for (int k = 0; k < 3; k++) begin
         iv[k] = 1'b0; ordy[k] = 1'b1; sx[k] = 1'b0; op_s[k] = '0; in1_s[k] = '0;
      end

      // Pin the model with hand-computed values.
      check("model sext w8", ext(32'd8, 1'b1, 32'hDEADBE80), 32'hFFFFFF80);
      check("model zext w8", ext(32'h28, 1'b0, 32'hDEADBE80), 32'h00000080);
      check("model w0", ext(32'd0, 1'b1, 32'hFFFFFFFF), 32'h0);
      check("model w31", ext(32'd31, 1'b1, 32'h40000000), 32'hC0000000);
      check("model F w8", fill_cycles(8, 4), 6);

      #1 rst_n = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) begin
         check("reset out", out_s[k], 32'h0);
         check("reset out_valid", ov[k], 1'b0);
         check("reset busy", bz[k], 1'b0);
         check("reset in_ready", ir[k], 1'b0);
      end
      @(posedge clk); @(posedge clk); #2;
      rst_n = 1'b1;
      @(posedge clk); #2;
      for (int k = 0; k < 3; k++) check("in_ready after reset", ir[k], 1'b1);

      run_dir(0, 32'd8, 1'b1, 32'hDEADBE80, 32'hFFFFFF80, 7, 1'b0);
      run_dir(0, 32'h28, 1'b0, 32'hDEADBE80, 32'h00000080, 7, 1'b0);
      run_dir(0, 32'd0, 1'b1, 32'hFFFFFFFF, 32'h00000000, 9, 1'b0);
      run_dir(0, 32'd31, 1'b1, 32'h40000000, 32'hC0000000, 2, 1'b0);

      // Backpressure: five DONE cycles with in_valid pulsed.
      run_dir(0, 32'd8, 1'b1, 32'hDEADBE80, 32'hFFFFFF80, 7, 1'b1);
      for (int i = 0; i < 5; i++) begin
         check("bp out stable", out_s[0], 32'hFFFFFF80);
         check("bp in_ready", ir[0], 1'b0);
         check("bp out_valid", ov[0], 1'b1);
         iv[0] = (i == 1 || i == 2);
         op_s[0] = 32'd4;
         in1_s[0] = 32'h12345678;
         @(posedge clk); #2;
      end
      iv[0] = 1'b0;
      ordy[0] = 1'b1;
      @(posedge clk); #2;
      check("bp idle in_ready", ir[0], 1'b1);
      check("bp idle out_valid", ov[0], 1'b0);
      repeat (3) begin
         @(posedge clk); #2;
         check("bp pulse not accepted", bz[0], 1'b0);
      end

      // Reset during FILL of a w=0 request.
      op_s[0] = 32'd0; sx[0] = 1'b1; in1_s[0] = 32'hFFFFFFFF; iv[0] = 1'b1;
      @(posedge clk); #2;
      iv[0] = 1'b0;
      @(posedge clk); #2;
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      check("mid reset busy", bz[0], 1'b0);
      check("mid reset out", out_s[0], 32'h0);
      check("mid reset out_valid", ov[0], 1'b0);
      @(posedge clk); @(posedge clk); #2;
      rst_n = 1'b1;
      seen = 0;
      repeat (12) begin
         @(posedge clk); #2;
         if (ov[0]) seen++;
      end
      check("no valid after reset", seen, 0);
      run_dir(0, 32'd16, 1'b1, 32'h00008001, 32'hFFFF8001, 5, 1'b0);

      // LANE sweep.
      run_dir(1, 32'd20, 1'b1, 32'h000FFFFF, 32'hFFFFFFFF, 13, 1'b0);
      run_dir(2, 32'd20, 1'b1, 32'h000FFFFF, 32'hFFFFFFFF, 2, 1'b0);

      // Random traffic on all instances, checked by the per-cycle compare.
      for (int c = 0; c < 4000; c++) begin
         for (int k = 0; k < 3; k++) begin
            iv[k]   = ($urandom_range(0, 2) == 0);
            op_s[k] = $urandom;
            sx[k]   = $urandom_range(0, 1) == 1;
            case ($urandom_range(0, 3))
               0: in1_s[k] = 32'hFFFFFFFF;
               1: in1_s[k] = 32'h0;
               2: in1_s[k] = 32'd1 << $urandom_range(0, 31);
               default: in1_s[k] = $urandom;
            endcase
            ordy[k] = ($urandom_range(0, 3) != 0);
         end
         @(posedge clk); #2;
      end
      for (int k = 0; k < 3; k++) begin
         iv[k] = 1'b0;
         ordy[k] = 1'b1;
      end
      repeat (40) @(posedge clk);
      #2;
      for (int k = 0; k < 3; k++) check("drained idle", bz[k], 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/g_lextend.md
# g_lextend

Sequential sign/zero extender, the inverse of the low-truncation stage in the G datapath. Takes a 32-bit word whose meaningful content is its low `op` bits, keeps those bits, and fills bits `op`..31 with either the sign bit `in1[op-1]` or zero. The upper fill runs LANE bits per cycle through a small FSM, with valid/ready handshakes on input and output. It sits between the truncation stage and the writeback/ALU consumer.

## Interface
- `LANE`, default 4: fill bits written per FILL cycle. Must be 1, 2, 4, 8 or 16.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous active-low reset.
- `in_valid` in 1: request present.
- `in_ready` out 1: block can accept a request.
- `op` in 32: kept-width code. Only `op[4:0]` is used (0..31). `op[31:5]` is ignored.
- `sext` in 1: 1 selects sign-extend, 0 selects zero-extend.
- `in1` in 32: source word.
- `out_valid` out 1: result available.
- `out_ready` in 1: consumer accepts the result.
- `out` out 32: extended result.
- `busy` out 1: high in FILL or DONE.

## Operation
- States are IDLE, FILL and DONE. Reset forces IDLE.
- `in_ready` is high only in IDLE, and is gated low while `rst_n`=0.
- **Accept:** the cycle with `in_valid && in_ready` in IDLE.
  - Let w = `op[4:0]`.
  - Register res = `in1` with bits w..31 cleared. For w=0, res = 0.
  - Register idx = w.
  - Register fill = `sext` & (w!=0) & `in1[w-1]`.
  - Next state is FILL.
- **FILL, each cycle:**
  - Write res bits idx..min(idx+LANE-1, 31) with fill.
  - idx <= idx+LANE. idx is 6 bits wide so it cannot wrap.
  - When idx+LANE >= 32, go to DONE.
  - Bits below w are never modified.
- **DONE:**
  - `out_valid`=1 and `out`=res. `out` is held stable until the handshake.
  - On `out_ready`=1, go to IDLE next cycle.
  - `in_valid` is ignored while not in IDLE. There is no queuing.
- `out` is driven from the registered res in every state. It is meaningful only while `out_valid`=1.
- w=0 produces 0 regardless of `sext`; no sign bit exists.
- w=31 with `sext` copies `in1[30]` into bit 31.
- **Reset mid-operation:** the transaction is abandoned and no `out_valid` pulse occurs.
- Reset values:
  - state = IDLE
  - `out` = 0
  - `out_valid` = 0
  - `busy` = 0
  - `in_ready` = 0 while asserted, 1 from the first cycle after release
  - idx = 0, fill = 0

## Timing
- Accept at cycle 0. FILL occupies cycles 1..F, where F = ceil((32-w)/LANE) and F >= 1.
- `out_valid` rises at cycle F+1.
  - With LANE=4: w=0 gives F=8, so valid at cycle 9. w=8 gives F=6, valid at 7. w=31 gives F=1, valid at 2.
- If `out_ready` is already high when `out_valid` rises, the result transfers that cycle and IDLE follows at F+2.
- The next accept is possible at F+2 at the earliest. Back-to-back throughput is one result per F+2 cycles.
- `busy` = (state != IDLE). `in_ready` = !`busy` && `rst_n`.
- All outputs are registered or decoded from registered state. There are no combinational paths from `in_*` to `out_*`.

## Test plan
- **Sign-extend, w=8:** `op`=8, `sext`=1, `in1`=0xDEADBE80 -> `out`=0xFFFFFF80, `out_valid` at cycle 7 (LANE=4).
- **Zero-extend, high op bits ignored:** `op`=0x28 (w=8), `sext`=0, `in1`=0xDEADBE80 -> `out`=0x00000080 at cycle 7.
- **Boundary w=0 and w=31:**
  - `op`=0, `sext`=1, `in1`=0xFFFFFFFF -> 0x00000000 at cycle 9.
  - `op`=31, `sext`=1, `in1`=0x40000000 -> 0xC0000000 at cycle 2.
- **Backpressure:** hold `out_ready`=0 for 5 cycles in DONE, with `in_valid` pulsed during that window.
  - `out` stays stable, `in_ready` stays 0, and the pulsed request is not accepted.
  - When `out_ready` goes to 1, the block returns to IDLE next cycle with `in_ready`=1.
- **Reset mid-FILL:** assert `rst_n`=0 at cycle 3 of a w=0 request.
  - `out_valid` never rises, and `out`=0 and `busy`=0 immediately.
  - After release, a new request `op`=16, `sext`=1, `in1`=0x00008001 -> 0xFFFF8001.
- **LANE sweep:** LANE=1 and LANE=16 with `op`=20, `sext`=1, `in1`=0x000FFFFF -> 0xFFFFFFFF.
  - LANE=1: `out_valid` at cycle 13.
  - LANE=16: `out_valid` at cycle 2.
